// File: rtl/send_arq_if.sv
// Handshake bundle between the ARQ send controller and its neighbours.
// master: the send controller. slave: router controller, get-data,
// encapsulate, fragment and receive-side ack source.
interface send_arq_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DFX_WIDTH     = 2,
  parameter int SEQ_NUM_WIDTH = 2
);
  logic                     req_start;
  logic [ADDR_WIDTH-1:0]    req_src_addr;
  logic [ADDR_WIDTH-1:0]    req_dst_addr;
  logic [DFX_WIDTH-1:0]     req_src_dfx;
  logic [DFX_WIDTH-1:0]     req_dst_dfx;
  logic                     busy;
  logic                     send_done;
  logic                     send_fail;
  logic                     start_get_data;
  logic [ADDR_WIDTH-1:0]    v_src_addr;
  logic [ADDR_WIDTH-1:0]    v_dst_addr;
  logic                     done_get_data;
  logic                     start_encap_pkt;
  logic [DFX_WIDTH-1:0]     pkt_src_dfx;
  logic [DFX_WIDTH-1:0]     pkt_dst_dfx;
  logic [SEQ_NUM_WIDTH-1:0] pkt_sn;
  logic                     done_encap_pkt;
  logic                     start_frag_pkt;
  logic                     frag_pkt_done;
  logic                     valid_ack_pkt;
  logic [SEQ_NUM_WIDTH-1:0] rn_ack_pkt;
  logic [DFX_WIDTH-1:0]     src_dfx_ack_pkt;

  modport master (
    input  req_start, req_src_addr, req_dst_addr, req_src_dfx, req_dst_dfx,
    input  done_get_data, done_encap_pkt, frag_pkt_done,
    input  valid_ack_pkt, rn_ack_pkt, src_dfx_ack_pkt,
    output busy, send_done, send_fail,
    output start_get_data, v_src_addr, v_dst_addr,
    output start_encap_pkt, pkt_src_dfx, pkt_dst_dfx, pkt_sn,
    output start_frag_pkt
  );

  modport slave (
    output req_start, req_src_addr, req_dst_addr, req_src_dfx, req_dst_dfx,
    output done_get_data, done_encap_pkt, frag_pkt_done,
    output valid_ack_pkt, rn_ack_pkt, src_dfx_ack_pkt,
    input  busy, send_done, send_fail,
    input  start_get_data, v_src_addr, v_dst_addr,
    input  start_encap_pkt, pkt_src_dfx, pkt_dst_dfx, pkt_sn,
    input  start_frag_pkt
  );
endinterface

// File: rtl/send_arq_controller.sv
// ARQ sender: get-data -> encapsulate -> fragment -> wait for ack, with
// per-destination sequence numbers, ack timeout and bounded retransmission.
// Optional retransmit/failure statistics are enabled with SEND_ARQ_STATS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a rising edge on req_start
// GET_DATA | start_get_data handshake with the data fetch block
// ENCAP    | start_encap_pkt handshake, header fields presented
// FRAG     | start_frag_pkt handshake, (re)transmit the held packet
// WAIT_ACK | ack timer running, checking acks from the destination
// REPORT   | one-cycle send_done / send_fail pulse
module send_arq_controller #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DFX_WIDTH      = 2,
  parameter int NUM_NODES      = 4,
  parameter int SEQ_NUM_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  send_arq_if.master  bus
`ifdef SEND_ARQ_STATS_EN
  ,
  output logic [15:0] stat_retx_cnt,
  output logic [15:0] stat_fail_cnt
`endif
);

  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int DW1     = DFX_WIDTH + 1;

  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [DW1-1:0]     NODE_LIM  = DW1'(NUM_NODES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    ENCAP    = 3'd2,
    FRAG     = 3'd3,
    WAIT_ACK = 3'd4,
    REPORT   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                     req_q;
  logic [ADDR_WIDTH-1:0]    src_addr_q;
  logic [ADDR_WIDTH-1:0]    dst_addr_q;
  logic [DFX_WIDTH-1:0]     src_dfx_q;
  logic [DFX_WIDTH-1:0]     dst_dfx_q;
  logic [TMR_W-1:0]         timer;
  logic [RETRY_W-1:0]       retry_cnt;
  logic                     result_ok;
  logic [SEQ_NUM_WIDTH-1:0] sn_tbl [NUM_NODES];

  logic start_gd_q, start_enc_q, start_frag_q;
  logic start_gd_nxt, start_enc_nxt, start_frag_nxt;

  logic                     req_rise;
  logic                     dst_in_ok;
  logic [SEQ_NUM_WIDTH-1:0] sn_cur;
  logic [SEQ_NUM_WIDTH-1:0] sn_plus;
  logic                     ack_hit;
  logic                     ack_ok;
  logic                     ack_nak;
  logic                     timeout;
  logic                     retx_need;
  logic                     retx_go;

  assign req_rise  = bus.req_start & ~req_q;
  // Destinations beyond the table are rejected before any downstream start.
  assign dst_in_ok = {1'b0, bus.req_dst_dfx} < NODE_LIM;
  assign sn_cur    = sn_tbl[dst_dfx_q];
  assign sn_plus   = sn_cur + SEQ_NUM_WIDTH'(1);
  assign ack_hit   = (state == WAIT_ACK) && bus.valid_ack_pkt &&
                     (bus.src_dfx_ack_pkt == dst_dfx_q);
  assign ack_ok    = ack_hit && (bus.rn_ack_pkt == sn_plus);
  assign ack_nak   = ack_hit && (bus.rn_ack_pkt == sn_cur);
  assign timeout   = (state == WAIT_ACK) && (timer == TMR_LAST);
  // A valid ack in the timeout cycle takes priority over the retransmit.
  assign retx_need = !ack_ok && (ack_nak || timeout);
  assign retx_go   = retx_need && (retry_cnt < RETRY_MAX);

  // State register and registered start handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_gd_q   <= 1'b0;
      start_enc_q  <= 1'b0;
      start_frag_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      start_gd_q   <= start_gd_nxt;
      start_enc_q  <= start_enc_nxt;
      start_frag_q <= start_frag_nxt;
    end
  end

  // Next-state decode; done_x only counts while its start is raised.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_rise) state_nxt = dst_in_ok ? GET_DATA : REPORT;
      GET_DATA: if (start_gd_q && bus.done_get_data) state_nxt = ENCAP;
      ENCAP:    if (start_enc_q && bus.done_encap_pkt) state_nxt = FRAG;
      FRAG:     if (start_frag_q && bus.frag_pkt_done) state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_ok)         state_nxt = REPORT;
        else if (retx_need) state_nxt = retx_go ? FRAG : REPORT;
      end
      REPORT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Start levels rise one cycle after entry and drop as the FSM leaves.
  always_comb begin
    start_gd_nxt   = (state == GET_DATA) && (state_nxt == GET_DATA);
    start_enc_nxt  = (state == ENCAP)    && (state_nxt == ENCAP);
    start_frag_nxt = (state == FRAG)     && (state_nxt == FRAG);
  end

  // Request latch, ack timer, retry count, result flag and sequence table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      src_dfx_q  <= '0;
      dst_dfx_q  <= '0;
      timer      <= '0;
      retry_cnt  <= '0;
      result_ok  <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) sn_tbl[i] <= '0;
    end else begin
      req_q <= bus.req_start;
      if (state == IDLE && req_rise) begin
        src_addr_q <= bus.req_src_addr;
        dst_addr_q <= bus.req_dst_addr;
        src_dfx_q  <= bus.req_src_dfx;
        dst_dfx_q  <= bus.req_dst_dfx;
      end
      if (state == FRAG)          timer <= '0;
      else if (state == WAIT_ACK) timer <= timer + TMR_W'(1);
      if (retx_go)               retry_cnt <= retry_cnt + RETRY_W'(1);
      else if (state == REPORT)  retry_cnt <= '0;
      if (ack_ok) sn_tbl[dst_dfx_q] <= sn_plus;
      if (state != REPORT && state_nxt == REPORT) result_ok <= ack_ok;
    end
  end

  assign bus.busy            = (state != IDLE);
  assign bus.send_done       = (state == REPORT) &&  result_ok;
  assign bus.send_fail       = (state == REPORT) && !result_ok;
  assign bus.start_get_data  = start_gd_q;
  assign bus.v_src_addr      = start_gd_q ? src_addr_q : '0;
  assign bus.v_dst_addr      = start_gd_q ? dst_addr_q : '0;
  assign bus.start_encap_pkt = start_enc_q;
  assign bus.pkt_src_dfx     = start_enc_q ? src_dfx_q : '0;
  assign bus.pkt_dst_dfx     = start_enc_q ? dst_dfx_q : '0;
  assign bus.pkt_sn          = start_enc_q ? sn_cur : '0;
  assign bus.start_frag_pkt  = start_frag_q;

`ifdef SEND_ARQ_STATS_EN
  // Saturating counters of retransmit decisions and reported failures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_retx_cnt <= '0;
      stat_fail_cnt <= '0;
    end else begin
      if (retx_go && stat_retx_cnt != 16'hFFFF)
        stat_retx_cnt <= stat_retx_cnt + 16'd1;
      if (bus.send_fail && stat_fail_cnt != 16'hFFFF)
        stat_fail_cnt <= stat_fail_cnt + 16'd1;
    end
  end
`endif

endmodule
